// File: rtl/led_band_fc_chain_setter_if.sv
// Signal bundle between the LED driver chain / config SPI host and the FC chain setter.
// Signal names follow the driver datasheet pins so the chain wiring reads directly.
interface led_band_fc_chain_setter_if;
  logic SCLK;
  logic LAT;
  logic SOUT;
  logic en;
  logic spi_clk;
  logic spi_data;
  logic spi_cs_n;
  logic cfg_loaded;
  logic fc_done;
  logic fc_error;

  modport master (
    output SCLK, LAT, spi_clk, spi_data, spi_cs_n,
    input  SOUT, en, cfg_loaded, fc_done, fc_error
  );

  modport slave (
    input  SCLK, LAT, spi_clk, spi_data, spi_cs_n,
    output SOUT, en, cfg_loaded, fc_done, fc_error
  );
endinterface

// File: rtl/led_band_fc_chain_setter.sv
// Serialises the function-control (FC) words for a daisy chain of LED drivers on SOUT,
// with an SPI-loaded shadow copy that is committed only while the chain is idle.
module led_band_fc_chain_setter #(
  parameter int                  FC_WIDTH      = 48,
  parameter int                  N_DRIVERS     = 4,
  parameter int                  FCWRTEN_SCLKS = 15,
  parameter int                  WRTFC_SCLKS   = 5,
  parameter logic [FC_WIDTH-1:0] DEFAULT_FC    = 48'h5c0201008048
) (
  input  logic                        clk,
  input  logic                        rst,
  led_band_fc_chain_setter_if.slave   bus
);
  localparam int TOTAL = N_DRIVERS * FC_WIDTH;
  localparam int IW    = $clog2(TOTAL);
  localparam int CW    = $clog2(TOTAL + 2);
  localparam int LMAX  = (FCWRTEN_SCLKS > WRTFC_SCLKS) ? FCWRTEN_SCLKS : WRTFC_SCLKS;
  localparam int LW    = $clog2(LMAX + 2);

  localparam logic [IW-1:0]    IDX_TOP  = IW'(TOTAL - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0]    CNT_SAT  = CW'(TOTAL + 1);
  localparam logic [LW-1:0]    LAT_SAT  = LW'(LMAX + 1);
  localparam logic [LW-1:0]    LAT_FCW  = LW'(FCWRTEN_SCLKS);
  localparam logic [LW-1:0]    LAT_WFC  = LW'(WRTFC_SCLKS);
  localparam logic [TOTAL-1:0] FC_RESET = {N_DRIVERS{DEFAULT_FC}};

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  function automatic logic [CW-1:0] sat_inc_bits(input logic [CW-1:0] v);
    return (v == CNT_SAT) ? v : v + CW'(1);
  endfunction

  function automatic logic [LW-1:0] sat_inc_lat(input logic [LW-1:0] v);
    return (v == LAT_SAT) ? v : v + LW'(1);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sclk_p1, r_lat_p1, r_spi_clk_p1, r_cs_n_p1;
  logic [TOTAL-1:0] r_shadow, r_active;
  logic [CW-1:0]    r_spi_cnt, r_fall_cnt;
  logic [LW-1:0]    r_lat_cnt;
  logic [IW-1:0]    r_idx;
  logic             r_exhausted, r_commit_pending;
  logic             r_cfg_loaded, r_fc_done, r_fc_error;
  logic             w_sclk_rise, w_sclk_fall, w_lat_fall, w_spi_rise, w_cs_rise, w_cs_fall;
  logic             w_fcwrten, w_wrtfc, w_restart, w_exit, w_en;
  logic             w_spi_ok, w_spi_err, w_commit;

  // Edge detection against the one-clk delayed copies
  assign w_sclk_rise = bus.SCLK & ~r_sclk_p1;
  assign w_sclk_fall = ~bus.SCLK & r_sclk_p1;
  assign w_lat_fall  = ~bus.LAT & r_lat_p1;
  assign w_spi_rise  = bus.spi_clk & ~r_spi_clk_p1;
  assign w_cs_rise   = bus.spi_cs_n & ~r_cs_n_p1;
  assign w_cs_fall   = ~bus.spi_cs_n & r_cs_n_p1;

  assign w_fcwrten = w_lat_fall && (r_lat_cnt == LAT_FCW);
  assign w_wrtfc   = w_lat_fall && (r_lat_cnt == LAT_WFC);
  assign w_spi_ok  = w_cs_rise && (r_spi_cnt == CNT_FULL);
  assign w_spi_err = w_cs_rise && (r_spi_cnt != CNT_FULL);
  assign w_en      = (r_state == S_IDLE);
  assign w_commit  = r_commit_pending && w_en;

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_exit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fcwrten) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_fcwrten) begin
          w_restart = 1'b1;
        end else if (w_wrtfc) begin
          w_state_nxt = S_IDLE;
          w_exit      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_sclk_p1        <= 1'b0;
      r_lat_p1         <= 1'b0;
      r_spi_clk_p1     <= 1'b0;
      r_cs_n_p1        <= 1'b1;
      r_shadow         <= FC_RESET;
      r_active         <= FC_RESET;
      r_spi_cnt        <= '0;
      r_fall_cnt       <= '0;
      r_lat_cnt        <= '0;
      r_idx            <= IDX_TOP;
      r_exhausted      <= 1'b0;
      r_commit_pending <= 1'b0;
      r_cfg_loaded     <= 1'b0;
      r_fc_done        <= 1'b0;
      r_fc_error       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sclk_p1    <= bus.SCLK;
      r_lat_p1     <= bus.LAT;
      r_spi_clk_p1 <= bus.spi_clk;
      r_cs_n_p1    <= bus.spi_cs_n;

      if (w_cs_fall) begin
        r_spi_cnt <= '0;
      end else if (!bus.spi_cs_n && w_spi_rise) begin
        r_shadow  <= {r_shadow[TOTAL-2:0], bus.spi_data};
        r_spi_cnt <= sat_inc_bits(r_spi_cnt);
      end

      // A commit waits for a registered en=1, so it never lands mid-shift
      if (w_commit) begin
        r_active         <= r_shadow;
        r_commit_pending <= 1'b0;
      end
      if (w_spi_ok) r_commit_pending <= 1'b1;

      if (!bus.LAT)        r_lat_cnt <= '0;
      else if (w_sclk_rise) r_lat_cnt <= sat_inc_lat(r_lat_cnt);

      // SCLK edges inside a LAT window are command clocks, not data clocks
      if (r_state == S_IDLE || w_restart || w_exit) begin
        r_idx       <= IDX_TOP;
        r_exhausted <= 1'b0;
        r_fall_cnt  <= '0;
      end else if (w_sclk_fall && !bus.LAT) begin
        if (r_idx == '0) r_exhausted <= 1'b1;
        else             r_idx       <= r_idx - IW'(1);
        r_fall_cnt <= sat_inc_bits(r_fall_cnt);
      end

      r_cfg_loaded <= w_commit;
      r_fc_done    <= w_exit && (r_fall_cnt == CNT_FULL);
      r_fc_error   <= w_spi_err || w_restart || (w_exit && (r_fall_cnt != CNT_FULL));
    end
  end

  assign bus.SOUT       = r_exhausted ? 1'b0 : r_active[r_idx];
  assign bus.en         = w_en;
  assign bus.cfg_loaded = r_cfg_loaded;
  assign bus.fc_done    = r_fc_done;
  assign bus.fc_error   = r_fc_error;
endmodule

// File: tb/tb_led_band_fc_chain_setter.sv
// Directed bench for a two-driver chain: FC writes, SPI reconfiguration, error and reset cases.
module tb_led_band_fc_chain_setter;
  localparam logic [47:0] DEF  = 48'h5c0201008048;
  localparam logic [95:0] DEF2 = {DEF, DEF};
  localparam logic [95:0] NEW  = 96'h0123456789abcdef01234567;
  localparam logic [95:0] NEW3 = 96'hfedcba9876543210a5a5a5a5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n_cfg = 0, n_done = 0, n_err = 0;

  led_band_fc_chain_setter_if bus();

  led_band_fc_chain_setter #(.N_DRIVERS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cfg_loaded) n_cfg++;
      if (bus.fc_done)    n_done++;
      if (bus.fc_error)   n_err++;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_pulses();
    n_cfg = 0; n_done = 0; n_err = 0;
  endtask

  task automatic sclk_pulse();
    bus.SCLK = 1'b1; tick(2);
    bus.SCLK = 1'b0; tick(2);
  endtask

  // LAT window with n SCLKs; LAT drops at the end, caller decides further ticks
  task automatic lat_cmd(input int n);
    bus.LAT = 1'b1; tick();
    for (int i = 0; i < n; i++) sclk_pulse();
    bus.LAT = 1'b0;
  endtask

  task automatic shift_bits(input int n, output logic [95:0] word, output int tail_ones,
                            output int en_high);
    word = '0; tail_ones = 0; en_high = 0;
    for (int i = 0; i < n; i++) begin
      if (i < 96) word = {word[94:0], bus.SOUT};
      else        tail_ones += int'(bus.SOUT);
      if (bus.en) en_high++;
      sclk_pulse();
    end
  endtask

  task automatic spi_send(input logic [95:0] data, input int n);
    bus.spi_cs_n = 1'b0; tick(2);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_data = data[i]; tick();
      bus.spi_clk = 1'b1; tick(2);
      bus.spi_clk = 1'b0; tick();
    end
    tick();
    bus.spi_cs_n = 1'b1;
  endtask

  task automatic full_write(input string name, input logic [95:0] exp);
    logic [95:0] w; int t; int e;
    clr_pulses();
    lat_cmd(15); tick(2);
    shift_bits(96, w, t, e);
    lat_cmd(5); tick(3);
    total++; if (w !== exp) begin bad++; $display("FAIL %s_data: got %h want %h", name, w, exp); end
    total++; if (n_done !== 1 || n_err !== 0) begin bad++;
      $display("FAIL %s_status: got done=%0d err=%0d want done=1 err=0", name, n_done, n_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3);
    total++; if (bus.en !== 1'b1) begin bad++; $display("FAIL rst_en: got %b want 1", bus.en); end
    total++; if (bus.SOUT !== DEF2[95]) begin bad++; $display("FAIL rst_sout: got %b want %b", bus.SOUT, DEF2[95]); end
    total++; if ({bus.cfg_loaded, bus.fc_done, bus.fc_error} !== 3'b000) begin bad++;
      $display("FAIL rst_pulses: got %b want 000", {bus.cfg_loaded, bus.fc_done, bus.fc_error}); end
    total++; if (dut.r_idx !== 7'd95) begin bad++; $display("FAIL rst_idx: got %0d want 95", dut.r_idx); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_default_write();
    logic [95:0] w; int t; int e;
    clr_pulses();
    lat_cmd(15); tick(2);
    total++; if (bus.en !== 1'b0) begin bad++; $display("FAIL dflt_en_enter: got %b want 0", bus.en); end
    shift_bits(96, w, t, e);
    total++; if (e !== 0) begin bad++; $display("FAIL dflt_en_low: got %0d en-high samples want 0", e); end
    lat_cmd(5); tick(3);
    total++; if (w !== DEF2) begin bad++; $display("FAIL dflt_data: got %h want %h", w, DEF2); end
    total++; if (bus.en !== 1'b1) begin bad++; $display("FAIL dflt_en_exit: got %b want 1", bus.en); end
    total++; if (n_done !== 1 || n_err !== 0) begin bad++;
      $display("FAIL dflt_status: got done=%0d err=%0d want done=1 err=0", n_done, n_err); end
  endtask

  task automatic test_spi_commit();
    clr_pulses();
    spi_send(NEW, 96);
    tick();
    total++; if (bus.cfg_loaded !== 1'b0) begin bad++; $display("FAIL spi_cfg_early: got %b want 0", bus.cfg_loaded); end
    tick();
    total++; if (bus.cfg_loaded !== 1'b1) begin bad++; $display("FAIL spi_cfg_pulse: got %b want 1", bus.cfg_loaded); end
    tick(2);
    total++; if (n_cfg !== 1 || n_err !== 0) begin bad++;
      $display("FAIL spi_cfg_count: got cfg=%0d err=%0d want cfg=1 err=0", n_cfg, n_err); end
    full_write("spi_new", NEW);
  endtask

  task automatic test_spi_short();
    clr_pulses();
    spi_send(NEW3, 95);
    tick(4);
    total++; if (n_err !== 1 || n_cfg !== 0) begin bad++;
      $display("FAIL short_frame: got err=%0d cfg=%0d want err=1 cfg=0", n_err, n_cfg); end
    full_write("short_keep", NEW);
  endtask

  task automatic test_commit_in_shift();
    logic [95:0] w1, w2; int t; int e;
    clr_pulses();
    lat_cmd(15); tick(2);
    shift_bits(50, w1, t, e);
    spi_send(NEW3, 96); tick(3);
    total++; if (n_cfg !== 0 || bus.en !== 1'b0) begin bad++;
      $display("FAIL shift_hold: got cfg=%0d en=%b want cfg=0 en=0", n_cfg, bus.en); end
    shift_bits(46, w2, t, e);
    total++; if ({w1[49:0], w2[45:0]} !== NEW) begin bad++;
      $display("FAIL shift_old_data: got %h want %h", {w1[49:0], w2[45:0]}, NEW); end
    lat_cmd(5); tick();
    total++; if (bus.en !== 1'b1 || bus.cfg_loaded !== 1'b0) begin bad++;
      $display("FAIL shift_exit: got en=%b cfg=%b want en=1 cfg=0", bus.en, bus.cfg_loaded); end
    tick();
    total++; if (bus.cfg_loaded !== 1'b1) begin bad++; $display("FAIL shift_deferred_cfg: got %b want 1", bus.cfg_loaded); end
    tick(2);
    full_write("shift_new", NEW3);
  endtask

  task automatic test_bad_counts();
    logic [95:0] w; int t; int e;
    clr_pulses();
    lat_cmd(15); tick(2);
    shift_bits(40, w, t, e);
    lat_cmd(5); tick(3);
    total++; if (n_err !== 1 || n_done !== 0 || bus.en !== 1'b1) begin bad++;
      $display("FAIL short_write: got err=%0d done=%0d en=%b want 1 0 1", n_err, n_done, bus.en); end
    clr_pulses();
    lat_cmd(15); tick(2);
    shift_bits(100, w, t, e);
    lat_cmd(5); tick(3);
    total++; if (w !== NEW3) begin bad++; $display("FAIL long_data: got %h want %h", w, NEW3); end
    total++; if (t !== 0) begin bad++; $display("FAIL long_tail: got %0d ones want 0", t); end
    total++; if (n_err !== 1 || n_done !== 0) begin bad++;
      $display("FAIL long_status: got err=%0d done=%0d want err=1 done=0", n_err, n_done); end
  endtask

  task automatic test_restart();
    logic [95:0] w; int t; int e;
    clr_pulses();
    lat_cmd(15); tick(2);
    shift_bits(10, w, t, e);
    lat_cmd(15); tick(2);
    total++; if (n_err !== 1 || bus.en !== 1'b0 || dut.r_idx !== 7'd95) begin bad++;
      $display("FAIL restart: got err=%0d en=%b idx=%0d want 1 0 95", n_err, bus.en, dut.r_idx); end
    clr_pulses();
    shift_bits(96, w, t, e);
    lat_cmd(5); tick(3);
    total++; if (w !== NEW3 || n_done !== 1 || n_err !== 0) begin bad++;
      $display("FAIL restart_write: got %h done=%0d err=%0d want %h 1 0", w, n_done, n_err, NEW3); end
  endtask

  task automatic test_reset_mid_shift();
    logic [95:0] w; int t; int e;
    clr_pulses();
    lat_cmd(15); tick(2);
    shift_bits(20, w, t, e);
    rst = 1'b1; tick();
    total++; if (bus.en !== 1'b1 || dut.r_idx !== 7'd95) begin bad++;
      $display("FAIL rst_mid: got en=%b idx=%0d want en=1 idx=95", bus.en, dut.r_idx); end
    tick(); rst = 1'b0; tick(4);
    total++; if (n_cfg + n_done + n_err !== 0) begin bad++;
      $display("FAIL rst_mid_pulses: got %0d want 0", n_cfg + n_done + n_err); end
    full_write("rst_restore", DEF2);
  endtask

  initial begin
    bus.SCLK = 1'b0; bus.LAT = 1'b0; bus.spi_clk = 1'b0;
    bus.spi_data = 1'b0; bus.spi_cs_n = 1'b1;
    test_reset();
    test_default_write();
    test_spi_commit();
    test_spi_short();
    test_commit_in_shift();
    test_bad_counts();
    test_restart();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_band_fc_chain_setter.md
LED_BAND_FC_CHAIN_SETTER -- requirements
Module: led_band_fc_chain_setter

Interface
REQ-001 The block SHALL have parameter FC_WIDTH, default 48: FC bits per driver.
REQ-002 The block SHALL have parameter N_DRIVERS, default 4: drivers daisy-chained on SOUT, range 1..16.
REQ-003 The block SHALL have parameter FCWRTEN_SCLKS, default 15: SCLK rising edges while LAT high that identify FCWRTEN.
REQ-004 The block SHALL have parameter WRTFC_SCLKS, default 5: SCLK rising edges while LAT high that identify WRTFC.
REQ-005 The block SHALL have parameter DEFAULT_FC, default 48'h5c0201008048: reset FC value, replicated to every driver.
REQ-006 The block SHALL have port clk, input, 1: single system clock; all logic on posedge clk.
REQ-007 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 The block SHALL have port SCLK, input, 1: driver shift clock, sampled on clk.
REQ-009 The block SHALL have port LAT, input, 1: driver latch line, sampled on clk.
REQ-010 The block SHALL have port SOUT, output, 1: FC serial data to the first driver, MSB first.
REQ-011 The block SHALL have port en, output, 1: low while the FC write owns SOUT.
REQ-012 The block SHALL have ports spi_clk, spi_data and spi_cs_n, each input, 1: configuration SPI; spi_cs_n is active-low.
REQ-013 The block SHALL have outputs cfg_loaded, fc_done and fc_error, each 1 bit: single-cycle status pulses.

Function
REQ-014 TOTAL SHALL equal N_DRIVERS*FC_WIDTH; the shadow and active registers SHALL each be TOTAL bits wide.
REQ-015 SCLK, LAT, spi_clk and spi_cs_n SHALL each be delayed one clk; an edge SHALL be current AND NOT previous (rising) or its inverse (falling).
REQ-016 While spi_cs_n is low, each spi_clk rising edge SHALL shift spi_data into shadow bit 0, shift the shadow up by one and increment the SPI bit counter, saturating at TOTAL+1.
REQ-017 On a spi_cs_n rising edge with bit count exactly TOTAL, the block SHALL set commit_pending; any other count SHALL discard the frame and pulse fc_error.
REQ-018 The SPI bit counter SHALL clear on a spi_cs_n falling edge.
REQ-019 When commit_pending and en are both high, the active register SHALL load from the shadow, commit_pending SHALL clear and cfg_loaded SHALL pulse that same cycle; the active register SHALL never change while en is low.
REQ-020 The LAT counter SHALL increment on each SCLK rising edge while LAT is high, saturate at max(FCWRTEN_SCLKS,WRTFC_SCLKS)+1, and clear when LAT is low.
REQ-021 FCWRTEN SHALL equal a LAT falling edge with LAT counter == FCWRTEN_SCLKS; WRTFC SHALL equal a LAT falling edge with LAT counter == WRTFC_SCLKS.
REQ-022 The FSM SHALL have two states, IDLE (en=1) and SHIFT (en=0); IDLE goes to SHIFT on FCWRTEN; SHIFT goes to IDLE on WRTFC.
REQ-023 FCWRTEN received in SHIFT SHALL restart the shift: idx returns to TOTAL-1 and fc_error pulses.
REQ-024 The bit index idx SHALL be loaded with TOTAL-1 in IDLE and on entry to SHIFT.
REQ-025 In SHIFT, each SCLK falling edge SHALL decrement idx; at idx==0 a further falling edge SHALL set an exhausted flag instead of wrapping.
REQ-026 SOUT SHALL equal active[idx], or 0 when the exhausted flag is set; the most distant driver's FC SHALL occupy active[TOTAL-1 -: FC_WIDTH].
REQ-027 On WRTFC in SHIFT, fc_done SHALL pulse if exactly TOTAL falling edges occurred; otherwise fc_error SHALL pulse. The exhausted flag SHALL clear on return to IDLE.
REQ-028 If a spi_cs_n rising edge and a WRTFC exit occur in the same cycle, the commit SHALL be deferred one cycle (until en=1 is registered).

Reset
REQ-029 While rst is high, the active and shadow registers SHALL hold DEFAULT_FC replicated N_DRIVERS times, and the state SHALL be IDLE with en=1.
REQ-030 While rst is high, idx SHALL equal TOTAL-1, all counters, flags and commit_pending SHALL be 0, cfg_loaded, fc_done and fc_error SHALL be 0, and SOUT SHALL be active[TOTAL-1].
REQ-031 A reset asserted mid-SHIFT or mid-SPI frame SHALL abort that operation with no status pulse.

Verification
REQ-032 Scenario, N_DRIVERS=2 defaults: after reset, LAT high for 15 SCLK, LAT low, 96 SCLK, then LAT high for 5 SCLK, LAT low -> SOUT gives 0x5c0201008048 twice MSB first, en low throughout, fc_done pulses once.
REQ-033 Scenario: SPI frame of 96 bits 0x0123..., spi_cs_n rises while IDLE -> cfg_loaded pulses 1 cycle later and the next write shifts the new data.
REQ-034 Scenario: SPI frame of 95 bits -> fc_error pulses, the active register is unchanged and cfg_loaded stays 0.
REQ-035 Scenario: SPI commit while in SHIFT -> SOUT keeps the old data, and cfg_loaded pulses in the cycle after en returns high.
REQ-036 Scenario: WRTFC after only 40 SCLK -> fc_error pulses and en=1; with 100 SCLK, bits 97..100 give SOUT=0 and fc_error pulses.
REQ-037 Scenario: rst asserted after 20 shifted bits -> en=1, idx=TOTAL-1 and no status pulse.
